// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type, S-box and xtime helpers
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam int KEY_W   = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[x];
   endfunction

   // Multiply by x in GF(2^8); 0x80 wraps to 0x1b.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - one full AES-128 round plus key expansion step, purely combinational
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] state,
   input  logic [KEY_W-1:0]   key,
   input  logic [7:0]         rcon,
   input  logic               last_round,
   output logic [BLOCK_W-1:0] state_next,
   output logic [KEY_W-1:0]   key_next
);

   // Byte 0 is the FIPS-197 in0 byte; bytes run down each column.
   logic [0:15][7:0] st_b;
   logic [0:15][7:0] sb;
   logic [0:15][7:0] sr;
   logic [0:15][7:0] mc;
   logic [0:15][7:0] kn_b;
   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign st_b = state;
   assign {w0, w1, w2, w3} = key;

   // Key schedule: SubWord(RotWord(w3)) ^ rcon, then chained XOR.
   assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon, 24'h000000};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign key_next = {n0, n1, n2, n3};
   assign kn_b     = key_next;

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sb[4*c+r] = sbox(st_b[4*c+r]);
         assign sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
      assign mc[4*c +: 4] = last_round ? sr[4*c +: 4] : mix_column(sr[4*c +: 4]);
   end

   assign state_next = mc ^ kn_b;

endmodule

// File: rtl/aes_rr_core.sv
// rtl/aes_rr_core.sv - iterative reduced-round AES-128 core; AES_RR_TRIGGER_EN enables the scope trigger
module aes_rr_core
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int TRIG_ROUND = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BLOCK_W-1:0] din,
   input  logic [KEY_W-1:0]   keyin,
   output logic               ready,
   output logic               busy,
   output logic [BLOCK_W-1:0] dout,
   output logic               dout_valid,
   output logic [3:0]         round_out,
   output logic               trigger
);

   localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS);

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
      $error("aes_rr_core: NUM_ROUNDS must be 1..10");
   end
   if (TRIG_ROUND < 1 || TRIG_ROUND > NUM_ROUNDS) begin : g_bad_trig
      $error("aes_rr_core: TRIG_ROUND must be 1..NUM_ROUNDS");
   end

   fsm_state_t         state_q, state_d;
   logic [BLOCK_W-1:0] state_reg, state_nx;
   logic [KEY_W-1:0]   key_reg, key_nx;
   logic [7:0]         rcon;
   logic [3:0]         round, round_d;
   logic               load, step, last;

   assign last = (round == LAST_R);

   aes_round_comb u_round (
      .state      (state_reg),
      .key        (key_reg),
      .rcon       (rcon),
      .last_round (last),
      .state_next (state_nx),
      .key_next   (key_nx)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, load/step strobes and next round index.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      round_d = round;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
               round_d = 4'd1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_d = DONE;
               round_d = 4'd0;
            end else begin
               round_d = round + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   // Datapath registers: load on accept, one round per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= '0;
         key_reg   <= '0;
         rcon      <= 8'h00;
         round     <= 4'd0;
      end else begin
         if (load) begin
            state_reg <= din ^ keyin;
            key_reg   <= keyin;
            rcon      <= 8'h01;
         end else if (step) begin
            state_reg <= state_nx;
            key_reg   <= key_nx;
            rcon      <= xtime(rcon);
         end
         round <= round_d;
      end
   end

   assign ready      = (state_q == IDLE) || (state_q == DONE);
   assign busy       = (state_q == RUN);
   assign dout_valid = (state_q == DONE);
   assign dout       = dout_valid ? state_reg : '0;
   assign round_out  = round;

`ifdef AES_RR_TRIGGER_EN
   localparam logic [3:0] TRIG_R = 4'(TRIG_ROUND);
   logic trig_q;

   // Trigger computed from next-state values so it lines up with round_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) trig_q <= 1'b0;
      else     trig_q <= (state_d == RUN) && (round_d == TRIG_R);
   end

   assign trigger = trig_q;
`else
   assign trigger = 1'b0;
`endif

endmodule
